// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared encodings and constants for the instruction fetch unit
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // 2'b11 is an alias of PC+4 so a stray encoding never stalls the core
    typedef enum logic [1:0] {
        PC_PLUS4     = 2'b00,
        PC_BRANCH    = 2'b01,
        PC_JALR      = 2'b10,
        PC_PLUS4_ALT = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory request/response bus
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_next_pc_gen.sv
// rtl/instr_fetch_next_pc_gen.sv - next PC selection and word-alignment check
module next_pc_gen
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_src_e'(pc_src))
            PC_BRANCH: next_pc = pc + imm_ext;
            // JALR drops bit 0 of the target; bit 1 is left for the alignment check
            PC_JALR:   next_pc = alu_result & ~32'd1;
            default:   next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = !word_aligned(next_pc);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch FSM with PC register
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    input  logic                 advance,
    input  logic [1:0]           PCSrc,
    input  logic [31:0]          ImmExt,
    input  logic [31:0]          ALUResult,
    output logic [31:0]          Instr,
    output logic                 instr_valid,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    output logic                 misalign_err
);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    next_pc_gen u_next_pc_gen (
        .pc         (pc_q),
        .pc_src     (PCSrc),
        .imm_ext    (ImmExt),
        .alu_result (ALUResult),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    // instr_q holds NOP whenever no fetched word is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_REQ;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem.imem_gnt) begin
                        if (imem.imem_rvalid) begin
                            instr_q     <= imem.imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= ST_VALID;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr_q     <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        instr_q     <= NOP_INSTR;
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= ST_HALT;
                        end else begin
                            pc_q  <= next_pc;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    // Gated by reset so no request leaks out while reset is held
    assign imem.imem_req  = (state == ST_REQ) && !reset;
    assign imem.imem_addr = pc_q;
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + 32'd4;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002: NOP_INSTR, 32'h0000_0013, value driven on Instr whenever instr_valid=0.
REQ-003: clk  input  1  sole clock; all state on rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: imem_req  output  1  fetch request to instruction memory.
REQ-006: imem_addr  output  32  fetch byte address; equals PC.
REQ-007: imem_gnt  input  1  memory accepted request this cycle.
REQ-008: imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-009: imem_rdata  input  32  fetched instruction word.
REQ-010: advance  input  1  decode/execute consumed current Instr; PCSrc/ImmExt/ALUResult valid.
REQ-011: PCSrc  input  2  next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JALR target, 11 PC+4.
REQ-012: ImmExt  input  32  sign-extended branch/JAL offset.
REQ-013: ALUResult  input  32  JALR base+offset.
REQ-014: Instr  output  32  instruction presented to decoder.
REQ-015: instr_valid  output  1  Instr holds a fetched word.
REQ-016: PC  output  32  address of Instr.
REQ-017: PCPlus4  output  32  PC+4, link value for JAL/JALR.
REQ-018: misalign_err  output  1  sticky: redirect target not word-aligned.

Function
REQ-019: FSM states REQ, WAIT, VALID, HALT; one state per cycle.
REQ-020: REQ: imem_req=1; gnt=1 and rvalid=0 -> WAIT; gnt=1 and rvalid=1 same cycle -> capture rdata, go VALID; gnt=0 -> stay, address held stable.
REQ-021: WAIT: imem_req=0; rvalid=1 -> capture imem_rdata into Instr register, go VALID; else stay (unbounded latency).
REQ-022: rvalid in REQ without gnt, in VALID or in HALT: ignored, no state change.
REQ-023: VALID: instr_valid=1, Instr stable until advance=1.
REQ-024: VALID and advance=1: PC <= next_pc, instr_valid=0 next cycle, go REQ; earliest next request one cycle after advance.
REQ-025: next_pc: 00/11 -> PC+4; 01 -> PC+ImmExt; 10 -> {ALUResult[31:1],1'b0}; all sums mod 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000).
REQ-026: advance ignored outside VALID.
REQ-027: next_pc[1:0]!=0 -> PC not updated, misalign_err=1, go HALT.
REQ-028: HALT: imem_req=0, instr_valid=0; only reset exits.
REQ-029: PCPlus4 combinational from PC register.
REQ-030: Best-case throughput: one instruction per 2 cycles (REQ with gnt+rvalid, VALID with advance).

Reset
REQ-031: On reset assertion, immediately: PC=RESET_PC, state=REQ, Instr register=NOP_INSTR, instr_valid=0, misalign_err=0.
REQ-032: imem_req=0 while reset asserted; request issued in first cycle after deassertion.
REQ-033: Reset mid-WAIT or mid-VALID discards the in-flight word; no response accepted until new WAIT.

Structure
REQ-034: Shared package holds PCSrc encodings (PC_PLUS4, PC_BRANCH, PC_JALR), FSM state encoding, NOP_INSTR.
REQ-035: One sub-module, next_pc_gen: combinational next_pc plus alignment check; FSM and registers in instr_fetch.

Verification
REQ-036: Reset release, gnt=1, rvalid=1 same cycle, rdata=0x00500093 -> Instr=0x00500093, PC=0, instr_valid=1 next cycle.
REQ-037: PC=0x100, WAIT held 5 cycles, then rvalid -> instr_valid rises one cycle after rvalid; imem_req low during wait.
REQ-038: PC=0x100, advance with PCSrc=01, ImmExt=0xFFFFFFF0 -> next imem_addr=0xF0; PCSrc=10, ALUResult=0x203 -> 0x202 -> misalign_err=1, HALT, imem_req=0.
REQ-039: PC=0xFFFFFFFC, PCSrc=00 advance -> imem_addr=0x00000000, PCPlus4 at prior PC=0x00000000.
REQ-040: Reset asserted in WAIT, late rvalid arrives during REQ after reset -> ignored, PC=RESET_PC, Instr=0x00000013.
REQ-041: gnt=0 for 3 cycles in REQ -> imem_addr stable, no state change; spurious rvalid in VALID -> Instr unchanged.
